// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for a shared-datapath MIPS core: sequences fetch/decode/execute,
// stalls on the memory handshake, counts retired instructions and halts on HALT/illegal opcodes.
module mips_multicycle_ctrl #(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             halted_reg;

    always_comb begin
        state_next    = state_reg;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        instr_done    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                // HALT_OP is checked first so it wins even if configured to a legal opcode
                if (opcode == HALT_OP) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode)
                        6'h00:        state_next = S_EXEC;
                        6'h23, 6'h2B: state_next = S_MEMADR;
                        6'h04:        state_next = S_BRANCH;
                        6'h02:        state_next = S_JUMP;
                        6'h08:        state_next = S_IEXEC;
                        default:      state_next = S_HALT;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                state_next = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'd2;
                state_next = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                state_next = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                instr_done    = 1'b1;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // The reset cycle must not issue memory or register side effects
        if (reset) begin
            state_next    = S_FETCH;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd0;
            alu_op        = 2'd0;
            pc_source     = 2'd0;
            instr_done    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == S_HALT);
            if (instr_done && (count_reg != {CNT_W{1'b1}}))
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign state       = state_reg;
    assign instr_count = count_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: stimulus pushes per-instruction expectations (latency and per-signal active-cycle
// counts derived from instruction class and stall counts); a negedge monitor checks each retirement.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [5:0]       opcode = 6'h00;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, halted;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    mips_multicycle_ctrl #(.CNT_W(CNT_W), .HALT_OP(6'h3F)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .instr_count(instr_count), .halted(halted)
    );

    always #5 clock = ~clock;

    wire [16:0] ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                        pc_source, instr_done};

    typedef struct packed {
        logic [7:0] lat, mr, mw, rw, irw, pcw, pcc, iod, m2r, rdst;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   model_n = 0;

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    // Expected activity of one instruction from its class and stall counts
    function automatic exp_t expect_of(input logic [5:0] op, input int sf, input int sm);
        exp_t e;
        bit is_lw, is_sw;
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2B);
        e = '0;
        e.irw = 8'd1;
        e.mr  = 8'(sf + 1 + (is_lw ? sm + 1 : 0));
        e.mw  = 8'(is_sw ? sm + 1 : 0);
        e.iod = 8'((is_lw || is_sw) ? sm + 1 : 0);
        e.rw  = 8'((op == 6'h00 || op == 6'h08 || is_lw) ? 1 : 0);
        e.m2r = 8'(is_lw ? 1 : 0);
        e.rdst = 8'((op == 6'h00) ? 1 : 0);
        e.pcw = 8'((op == 6'h02) ? 2 : 1);
        e.pcc = 8'((op == 6'h04) ? 1 : 0);
        case (op)
            6'h00, 6'h08: e.lat = 8'(sf + 4);
            6'h23:        e.lat = 8'(sf + sm + 5);
            6'h2B:        e.lat = 8'(sf + sm + 4);
            default:      e.lat = 8'(sf + 3);
        endcase
        return e;
    endfunction

    // Each task starts and ends at posedge+1
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
        exp_t e;
        bit   mem_op;
        e = expect_of(op, sf, sm);
        mem_op = (op == 6'h23) || (op == 6'h2B);
        exp_q.push_back(e);
        opcode = op;
        for (int k = 0; k < int'(e.lat); k++) begin
            if (k < sf)                                   mem_ready = 1'b0;
            else if (k == sf)                             mem_ready = 1'b1;
            else if (mem_op && k >= sf + 3 && k < sf + 3 + sm) mem_ready = 1'b0;
            else if (mem_op && k == sf + 3 + sm)          mem_ready = 1'b1;
            else                                          mem_ready = 1'($urandom);
            @(posedge clock); #1;
        end
    endtask

    task automatic run_halt(input logic [5:0] op, input int sf);
        opcode = op;
        for (int k = 0; k < sf + 2; k++) begin
            mem_ready = (k < sf) ? 1'b0 : 1'b1;
            @(posedge clock); #1;
        end
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom);
            @(negedge clock);
            vectors++;
            if ({halted, state, ctrl, instr_count} != {1'b1, 4'd12, 17'd0, 4'(sat(model_n))}) begin
                miscompares++;
                $display("FAIL halt op=%h cyc=%0d: halted=%b state=%0d ctrl=%h count=%0d, want 1/12/0/%0d",
                         op, c, halted, state, ctrl, instr_count, sat(model_n));
            end
            @(posedge clock); #1;
        end
    endtask

    // Monitor: counts per-instruction activity and checks it at each retirement
    initial begin
        int   cyc, mr, mw, rw, irw, pcw, pcc, iod, m2r, rdst;
        bit   prev_reset;
        exp_t e, a;
        cyc = 0; mr = 0; mw = 0; rw = 0; irw = 0; pcw = 0; pcc = 0; iod = 0; m2r = 0; rdst = 0;
        prev_reset = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                vectors++;
                if (ctrl != 17'd0) begin
                    miscompares++;
                    $display("FAIL reset_ctrl: ctrl=%h want 0", ctrl);
                end
                exp_q.delete();
                model_n = 0;
                cyc = 0; mr = 0; mw = 0; rw = 0; irw = 0; pcw = 0; pcc = 0; iod = 0; m2r = 0; rdst = 0;
                prev_reset = 1'b1;
                continue;
            end
            if (prev_reset) begin
                vectors++;
                if ({state, instr_count, halted, mem_read} != {4'd0, 4'd0, 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL post_reset: state=%0d count=%0d halted=%b mem_read=%b want 0/0/0/1",
                             state, instr_count, halted, mem_read);
                end
                prev_reset = 1'b0;
            end
            if (mem_read && mem_write) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_wr_excl: mem_read and mem_write both high state=%0d", state);
            end
            cyc++; mr += int'(mem_read); mw += int'(mem_write); rw += int'(reg_write);
            irw += int'(ir_write); pcw += int'(pc_write); pcc += int'(pc_write_cond);
            iod += int'(i_or_d); m2r += int'(mem_to_reg); rdst += int'(reg_dst);
            if (instr_done) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL retire_unexpected: instr_done with no pending instruction state=%0d", state);
                end else begin
                    e = exp_q.pop_front();
                    a = {8'(cyc), 8'(mr), 8'(mw), 8'(rw), 8'(irw), 8'(pcw), 8'(pcc), 8'(iod), 8'(m2r), 8'(rdst)};
                    if (a != e) begin
                        miscompares++;
                        $display("FAIL retire: lat/mr/mw/rw/irw/pcw/pcc/iod/m2r/rdst got %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                                 a.lat, a.mr, a.mw, a.rw, a.irw, a.pcw, a.pcc, a.iod, a.m2r, a.rdst,
                                 e.lat, e.mr, e.mw, e.rw, e.irw, e.pcw, e.pcc, e.iod, e.m2r, e.rdst);
                    end
                end
                vectors++;
                if (instr_count != 4'(sat(model_n))) begin
                    miscompares++;
                    $display("FAIL count: instr_count=%0d want %0d", instr_count, sat(model_n));
                end
                model_n++;
                cyc = 0; mr = 0; mw = 0; rw = 0; irw = 0; pcw = 0; pcc = 0; iod = 0; m2r = 0; rdst = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops [6];
        int wait_cnt;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h02; ops[5] = 6'h08;
        @(posedge clock); #1;
        do_reset();
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 3, 2);
        run_instr(6'h08, 0, 0);
        run_instr(6'h2B, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_halt(6'h3F, 1);
        do_reset();
        run_instr(6'h08, 0, 0);
        run_halt(6'h11, 0);
        do_reset();
        // Reset during a stalled load read
        opcode = 6'h23;
        mem_ready = 1'b1;
        @(posedge clock); #1;
        mem_ready = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        do_reset();
        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(5, 0)], $urandom_range(3, 0), $urandom_range(3, 0));
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(posedge clock); #1;
            wait_cnt++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d instructions never retired", exp_q.size());
        end
        @(negedge clock);
        vectors++;
        if (instr_count != 4'(sat(model_n))) begin
            miscompares++;
            $display("FAIL final_count: instr_count=%0d want %0d", instr_count, sat(model_n));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
